// File: rtl/izhikevich_array.sv
// izhikevich_array: time-multiplexed engine advancing NUM_NEURONS Izhikevich
// neurons by one Euler step per start command, using a shared 3-stage datapath.
// Host loads parameters/state/current through the cfg port; rd port is a
// registered readback. Optional macro IZH_SPIKE_CNT_EN adds per-neuron 8-bit
// saturating spike counters (read with rd_sel=7, cleared with cfg_sel=7).
module izhikevich_array #(
    parameter int WIDTH       = 17,
    parameter int FRAC        = 8,
    parameter int NUM_NEURONS = 16,
    parameter int AW          = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [2:0]             cfg_sel,
    input  logic [WIDTH-1:0]       cfg_wdata,
    output logic                   cfg_err,
    input  logic [2:0]             rd_sel,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] fired_vec
);

    localparam int XW    = 2 * WIDTH + 4;
    localparam int NBANK = 7;
    localparam int SEL_A = 0;
    localparam int SEL_B = 1;
    localparam int SEL_C = 2;
    localparam int SEL_D = 3;
    localparam int SEL_V = 4;
    localparam int SEL_U = 5;
    localparam int SEL_I = 6;
    localparam logic [2:0] SEL_CNT = 3'd7;

    // 0.04 in fixed point, rounded to nearest
    localparam logic signed [XW-1:0]    K04      = XW'(((4 << FRAC) + 50) / 100);
    localparam logic signed [XW-1:0]    K5       = XW'(5);
    localparam logic signed [XW-1:0]    C140     = XW'(140) <<< FRAC;
    localparam logic signed [XW-1:0]    SAT_HI   = XW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0]    SAT_LO   = -SAT_HI - XW'(1);
    localparam logic signed [WIDTH-1:0] V_PEAK   = WIDTH'(30 << FRAC);
    localparam logic [AW-1:0]           LAST_IDX = AW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
        if (x > SAT_HI) return SAT_HI[WIDTH-1:0];
        if (x < SAT_LO) return SAT_LO[WIDTH-1:0];
        return x[WIDTH-1:0];
    endfunction

    state_t                   state, state_nx;
    logic [AW-1:0]            issue_cnt, issue_cnt_nx;
    logic [1:0]               drain_cnt, drain_cnt_nx;
    logic                     issue_vld;
    logic                     start_acc;

    logic signed [WIDTH-1:0]  bank [NBANK][NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   shadow;

    logic                     cfg_addr_ok, cfg_sel_ok, cfg_acc;
    logic                     rd_addr_ok;

    // Stage 1 registers
    logic                     s1_vld;
    logic [AW-1:0]            s1_idx;
    logic signed [WIDTH-1:0]  s1_v, s1_u, s1_a, s1_c, s1_d, s1_i;
    logic signed [XW-1:0]     s1_sq, s1_bv;

    // Stage 2 registers
    logic                     s2_vld;
    logic [AW-1:0]            s2_idx;
    logic signed [XW-1:0]     s2_vn, s2_un;
    logic signed [WIDTH-1:0]  s2_c, s2_d;

    // Combinational datapath nets
    logic signed [XW-1:0]     rd_v_x, rd_b_x, sq_c, bv_c;
    logic signed [XW-1:0]     v_x, u_x, a_x, i_x, t_c, vn_c, un_c;
    logic signed [WIDTH-1:0]  vs_c, us_c, ud_c, wb_v, wb_u;
    logic                     spike;

    assign busy      = (state != IDLE);
    assign issue_vld = (state == RUN);
    assign start_acc = (state == IDLE) && start;

    assign cfg_addr_ok = 32'(cfg_addr) < NUM_NEURONS;
    assign rd_addr_ok  = 32'(rd_addr) < NUM_NEURONS;
`ifdef IZH_SPIKE_CNT_EN
    assign cfg_sel_ok  = 1'b1;
`else
    assign cfg_sel_ok  = (cfg_sel != SEL_CNT);
`endif
    assign cfg_acc = cfg_we && (state == IDLE) && cfg_addr_ok && cfg_sel_ok;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            issue_cnt <= issue_cnt_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    // FSM next state: sweep indices, drain the pipeline, then complete
    always_comb begin
        state_nx     = state;
        issue_cnt_nx = issue_cnt;
        drain_cnt_nx = drain_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx     = RUN;
                    issue_cnt_nx = '0;
                end
            end
            RUN: begin
                if (issue_cnt == LAST_IDX) begin
                    state_nx     = DRAIN;
                    drain_cnt_nx = '0;
                end else begin
                    issue_cnt_nx = issue_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd2) state_nx = DONE;
                else                   drain_cnt_nx = drain_cnt + 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage 1 arithmetic: square and b*v from the bank read of the issued index
    always_comb begin
        rd_v_x = XW'(bank[SEL_V][issue_cnt]);
        rd_b_x = XW'(bank[SEL_B][issue_cnt]);
        sq_c   = (rd_v_x * rd_v_x) >>> FRAC;
        bv_c   = (rd_b_x * rd_v_x) >>> FRAC;
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            s1_v   <= '0;
            s1_u   <= '0;
            s1_a   <= '0;
            s1_c   <= '0;
            s1_d   <= '0;
            s1_i   <= '0;
            s1_sq  <= '0;
            s1_bv  <= '0;
        end else begin
            s1_vld <= issue_vld;
            if (issue_vld) begin
                s1_idx <= issue_cnt;
                s1_v   <= bank[SEL_V][issue_cnt];
                s1_u   <= bank[SEL_U][issue_cnt];
                s1_a   <= bank[SEL_A][issue_cnt];
                s1_c   <= bank[SEL_C][issue_cnt];
                s1_d   <= bank[SEL_D][issue_cnt];
                s1_i   <= bank[SEL_I][issue_cnt];
                s1_sq  <= sq_c;
                s1_bv  <= bv_c;
            end
        end
    end

    // Stage 2 arithmetic: membrane and recovery updates at full precision
    always_comb begin
        v_x  = XW'(s1_v);
        u_x  = XW'(s1_u);
        a_x  = XW'(s1_a);
        i_x  = XW'(s1_i);
        t_c  = (K04 * s1_sq) >>> FRAC;
        vn_c = v_x + t_c + K5 * v_x + C140 - u_x + i_x;
        un_c = u_x + ((a_x * (s1_bv - u_x)) >>> FRAC);
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_idx <= '0;
            s2_vn  <= '0;
            s2_un  <= '0;
            s2_c   <= '0;
            s2_d   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_idx <= s1_idx;
                s2_vn  <= vn_c;
                s2_un  <= un_c;
                s2_c   <= s1_c;
                s2_d   <= s1_d;
            end
        end
    end

    // Stage 3: saturate and apply the spike/reset rule
    always_comb begin
        vs_c  = sat(s2_vn);
        us_c  = sat(s2_un);
        ud_c  = sat(XW'(us_c) + XW'(s2_d));
        spike = s2_vld && (vs_c >= V_PEAK);
        wb_v  = spike ? s2_c : vs_c;
        wb_u  = spike ? ud_c : us_c;
    end

    // Register banks: host writes in IDLE, pipeline writeback while stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NBANK; s++)
                for (int unsigned n = 0; n < NUM_NEURONS; n++)
                    bank[s][n] <= '0;
        end else begin
            if (cfg_acc && cfg_sel != SEL_CNT)
                bank[cfg_sel][cfg_addr] <= cfg_wdata;
            if (s2_vld) begin
                bank[SEL_V][s2_idx] <= wb_v;
                bank[SEL_U][s2_idx] <= wb_u;
            end
        end
    end

    // Shadow spike register collects this step's spikes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            shadow <= '0;
        else if (start_acc) shadow <= '0;
        else if (spike)     shadow[s2_idx] <= 1'b1;
    end

    // Step completion: done pulse and spike vector publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            fired_vec <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) fired_vec <= shadow;
        end
    end

    // Reject pulse for writes that are busy, out of range, or unsupported
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= cfg_we && !cfg_acc;
    end

`ifdef IZH_SPIKE_CNT_EN
    logic [7:0] spike_cnt [NUM_NEURONS];

    // Saturating per-neuron spike counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < NUM_NEURONS; n++) spike_cnt[n] <= '0;
        end else begin
            if (cfg_acc && cfg_sel == SEL_CNT)
                spike_cnt[cfg_addr] <= '0;
            else if (spike && spike_cnt[s2_idx] != 8'hFF)
                spike_cnt[s2_idx] <= spike_cnt[s2_idx] + 8'd1;
        end
    end
`endif

    // Registered readback of the selected bank entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!rd_addr_ok) begin
            rd_data <= '0;
        end else if (rd_sel == SEL_CNT) begin
`ifdef IZH_SPIKE_CNT_EN
            rd_data <= WIDTH'(spike_cnt[rd_addr]);
`else
            rd_data <= '0;
`endif
        end else begin
            rd_data <= bank[rd_sel][rd_addr];
        end
    end

endmodule

// File: tb/tb_izhikevich_array.sv
// Directed bench for izhikevich_array with a behavioural step model and a
// readback scoreboard. Build with IZH_SPIKE_CNT_EN to cover spike counters.
module tb_izhikevich_array;

    localparam int N    = 16;
    localparam int W    = 17;
    localparam int FRAC = 8;
    localparam int AW   = 4;
    localparam longint K04_M = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we, start;
    logic [AW-1:0]  cfg_addr, rd_addr;
    logic [2:0]     cfg_sel, rd_sel;
    logic [W-1:0]   cfg_wdata, rd_data;
    logic           cfg_err, busy, done;
    logic [N-1:0]   fired_vec;

    logic           s_cfg_we, s_start;
    logic [3:0]     s_cfg_addr, s_rd_addr;
    logic [2:0]     s_cfg_sel, s_rd_sel;
    logic [W-1:0]   s_cfg_wdata, s_rd_data;
    logic           s_cfg_err, s_busy, s_done;
    logic [11:0]    s_fired_vec;

    always #5 clk = ~clk;

    izhikevich_array #(.WIDTH(W), .FRAC(FRAC), .NUM_NEURONS(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data), .start(start), .busy(busy), .done(done), .fired_vec(fired_vec)
    );

    izhikevich_array #(.WIDTH(W), .FRAC(FRAC), .NUM_NEURONS(12), .AW(4)) dut_small (
        .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr), .cfg_sel(s_cfg_sel),
        .cfg_wdata(s_cfg_wdata), .cfg_err(s_cfg_err), .rd_sel(s_rd_sel), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .start(s_start), .busy(s_busy), .done(s_done),
        .fired_vec(s_fired_vec)
    );

    int                n_checks = 0;
    int                n_errs   = 0;
    logic [31:0]       exp_q[$];

    logic signed [W-1:0] m_bank [7][N];
    logic [7:0]          m_cnt  [N];
    logic [N-1:0]        m_fired;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sat_m(input longint x);
        if (x > 65535)  return 65535;
        if (x < -65536) return -65536;
        return x;
    endfunction

    function automatic logic [31:0] exp_rd(input int sel, input int addr);
        if (sel < 7) return {15'd0, m_bank[sel][addr]};
`ifdef IZH_SPIKE_CNT_EN
        return {24'd0, m_cnt[addr]};
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 7; s++)
            for (int n = 0; n < N; n++) m_bank[s][n] = '0;
        for (int n = 0; n < N; n++) m_cnt[n] = '0;
        m_fired = '0;
    endtask

    task automatic model_step();
        m_fired = '0;
        for (int n = 0; n < N; n++) begin
            longint v, u, a, b, c, d, i, sq, bv, t, vn, un, vs, us;
            v = longint'(m_bank[4][n]);
            u = longint'(m_bank[5][n]);
            a = longint'(m_bank[0][n]);
            b = longint'(m_bank[1][n]);
            c = longint'(m_bank[2][n]);
            d = longint'(m_bank[3][n]);
            i = longint'(m_bank[6][n]);
            sq = (v * v) >>> FRAC;
            bv = (b * v) >>> FRAC;
            t  = (K04_M * sq) >>> FRAC;
            vn = v + t + 5 * v + (140 <<< FRAC) - u + i;
            un = u + ((a * (bv - u)) >>> FRAC);
            vs = sat_m(vn);
            us = sat_m(un);
            if (vs >= (30 <<< FRAC)) begin
                m_bank[4][n] = W'(c);
                m_bank[5][n] = W'(sat_m(us + d));
                m_fired[n]   = 1'b1;
                if (m_cnt[n] != 8'hFF) m_cnt[n] = m_cnt[n] + 8'd1;
            end else begin
                m_bank[4][n] = W'(vs);
                m_bank[5][n] = W'(us);
            end
        end
    endtask

    task automatic cfg_wr(input int sel, input int addr, input logic [W-1:0] data,
                          input bit exp_err, input string tag);
        cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_addr = AW'(addr); cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
        check(tag, cfg_err, exp_err);
        if (!exp_err) begin
            if (sel < 7) m_bank[sel][addr] = data;
            else         m_cnt[addr] = '0;
        end
    endtask

    task automatic rd_chk(input int sel, input int addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        rd_sel = 3'(sel); rd_addr = AW'(addr);
        tick();
        check(tag, rd_data, exp_q.pop_front());
    endtask

    task automatic read_vu(input string tag);
        for (int n = 0; n < N; n++) begin
            rd_chk(4, n, exp_rd(4, n), {tag, ":v"});
            rd_chk(5, n, exp_rd(5, n), {tag, ":u"});
        end
    endtask

    task automatic read_all(input string tag);
        for (int s = 0; s < 8; s++)
            for (int n = 0; n < N; n++) rd_chk(s, n, exp_rd(s, n), tag);
    endtask

    task automatic run_step(input bit poke, input string tag);
        int done_at;
        int ndone;
        done_at = 0;
        ndone   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ":busy_rise"}, busy, 1);
        for (int k = 1; k <= N + 12; k++) begin
            if (poke && k == 2) begin
                cfg_we = 1'b1; cfg_sel = 3'd6; cfg_addr = AW'(2); cfg_wdata = 17'h00600;
            end
            if (poke && k == 4) start = 1'b1;
            tick();
            if (poke && k == 2) begin
                cfg_we = 1'b0;
                check({tag, ":busy_write_err"}, cfg_err, 1);
            end
            if (poke && k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
        end
        check({tag, ":done_latency"}, done_at, N + 4);
        check({tag, ":done_count"}, ndone, 1);
        model_step();
        check({tag, ":fired_vec"}, fired_vec, m_fired);
        check({tag, ":busy_fall"}, busy, 0);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_wdata = '0;
        rd_sel = '0; rd_addr = '0;
        s_cfg_we = 1'b0; s_start = 1'b0; s_cfg_addr = '0; s_cfg_sel = '0; s_cfg_wdata = '0;
        s_rd_sel = '0; s_rd_addr = '0;
        model_clear();
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_fired", fired_vec, 0);
        tick(); tick();
        rst = 1'b0;
        read_all("reset_read");

        // Address range on a non-power-of-two array
        s_cfg_we = 1'b1; s_cfg_sel = 3'd4; s_cfg_addr = 4'd12; s_cfg_wdata = 17'h00055;
        tick();
        check("small_addr12_err", s_cfg_err, 1);
        s_cfg_addr = 4'd11; s_cfg_wdata = 17'h12345;
        tick();
        s_cfg_we = 1'b0;
        check("small_addr11_ok", s_cfg_err, 0);
        s_rd_sel = 3'd4; s_rd_addr = 4'd11; exp_q.push_back(32'h12345);
        tick();
        check("small_rd11", s_rd_data, exp_q.pop_front());
        s_rd_addr = 4'd13; exp_q.push_back(32'h0);
        tick();
        check("small_rd13_zero", s_rd_data, exp_q.pop_front());

        // Quiescent background: u = 140 cancels the constant drive
        for (int n = 0; n < N; n++) cfg_wr(5, n, 17'h08C00, 0, "init_u");

        // Neuron 3 fires from rest
        cfg_wr(5, 3, 17'h00000, 0, "n3_u");
        cfg_wr(0, 3, 17'h00005, 0, "n3_a");
        cfg_wr(1, 3, 17'h00033, 0, "n3_b");
        cfg_wr(2, 3, 17'h1BF00, 0, "n3_c");
        cfg_wr(3, 3, 17'h00800, 0, "n3_d");
        run_step(0, "step_n3");
        check("n3_fired_const", fired_vec, 16'h0008);
        rd_chk(4, 3, 32'h1BF00, "n3_v_const");
        rd_chk(5, 3, 32'h00800, "n3_u_const");
        read_vu("after_n3");

        // Neuron 0 recovery decay
        cfg_wr(5, 0, 17'h08C00, 0, "n0_u");
        cfg_wr(0, 0, 17'h00080, 0, "n0_a");
        run_step(0, "step_n0");
        rd_chk(4, 0, 32'h00000, "n0_v_const");
        rd_chk(5, 0, 32'h04600, "n0_u_const");
        check("n0_bit_clear", fired_vec[0], 0);

        // Neuron 1 saturates and fires; neuron 5 exercises negative truncation
        cfg_wr(4, 1, 17'h0C800, 0, "n1_v");
        cfg_wr(5, 1, 17'h00000, 0, "n1_u");
        cfg_wr(0, 1, 17'h00005, 0, "n1_a");
        cfg_wr(1, 1, 17'h00033, 0, "n1_b");
        cfg_wr(2, 1, 17'h1BF00, 0, "n1_c");
        cfg_wr(3, 1, 17'h00800, 0, "n1_d");
        cfg_wr(4, 5, 17'h1E0C5, 0, "n5_v");
        cfg_wr(5, 5, 17'h1FC33, 0, "n5_u");
        cfg_wr(0, 5, 17'h00005, 0, "n5_a");
        cfg_wr(1, 5, 17'h00033, 0, "n5_b");
        cfg_wr(6, 5, 17'h00A00, 0, "n5_i");
        run_step(0, "step_n1");
        rd_chk(4, 1, 32'h1BF00, "n1_v_is_c");
        rd_chk(5, 1, 32'h008C7, "n1_u_const");
        rd_chk(5, 5, 32'h1FC26, "n5_u_const");
        read_vu("after_n1");

        // Write and same-cycle read of the same entry sees the old value
        rd_sel = 3'd6; rd_addr = AW'(7);
        exp_q.push_back(exp_rd(6, 7));
        cfg_we = 1'b1; cfg_sel = 3'd6; cfg_addr = AW'(7); cfg_wdata = 17'h00123;
        tick();
        cfg_we = 1'b0;
        check("rw_same_old", rd_data, exp_q.pop_front());
        check("rw_same_err", cfg_err, 0);
        m_bank[6][7] = 17'h00123;
        rd_chk(6, 7, exp_rd(6, 7), "rw_same_new");

        // Busy write rejected and repeated start ignored
        run_step(1, "step_busy");
        rd_chk(6, 2, 32'h0, "i2_unchanged");
        read_vu("after_busy");

`ifdef IZH_SPIKE_CNT_EN
        rd_chk(7, 3, exp_rd(7, 3), "cnt3_early");
        rd_chk(7, 1, exp_rd(7, 1), "cnt1_early");
`else
        rd_chk(7, 3, 32'h0, "sel7_read_zero");
        cfg_wr(7, 3, 17'h00000, 1, "sel7_write_err");
`endif

        // Reset in the middle of a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        tick(); tick();
        rst = 1'b0;
        model_clear();
        ndone = 0;
        for (int k = 0; k < N + 8; k++) begin
            tick();
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_fired", fired_vec, 0);
        read_all("midrst_read");

`ifdef IZH_SPIKE_CNT_EN
        for (int n = 0; n < N; n++) cfg_wr(5, n, 17'h08C00, 0, "cnt_init_u");
        cfg_wr(0, 3, 17'h00005, 0, "cnt_n3_a");
        cfg_wr(1, 3, 17'h00033, 0, "cnt_n3_b");
        cfg_wr(2, 3, 17'h1BF00, 0, "cnt_n3_c");
        cfg_wr(3, 3, 17'h00800, 0, "cnt_n3_d");
        for (int r = 0; r < 300; r++) begin
            cfg_wr(4, 3, 17'h00000, 0, "cnt_v3");
            cfg_wr(5, 3, 17'h00000, 0, "cnt_u3");
            run_step(0, "cnt_step");
        end
        rd_chk(7, 3, 32'd255, "cnt3_sat_const");
        rd_chk(7, 3, exp_rd(7, 3), "cnt3_model");
        rd_chk(7, 0, exp_rd(7, 0), "cnt0_model");
        cfg_wr(7, 3, 17'h1ABCD, 0, "cnt_clear_write");
        rd_chk(7, 3, 32'd0, "cnt3_cleared");
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
